// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared HI/LO op and FSM state encodings
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - 32-cycle restoring unsigned divider datapath
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // The quotient register starts as the dividend and shifts its top bit
    // into the partial remainder while quotient bits enter from the bottom.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        fits    = shifted >= {1'b0, dvs_q};
        diff    = shifted[31:0] - dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        if (load) begin
            rem_d = 32'd0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = 5'd0;
        end else if (en) begin
            rem_d = fits ? diff : shifted[31:0];
            quo_d = {quo_q[30:0], fits};
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dvs_q <= 32'd0;
            cnt_q <= 5'd0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = en && (cnt_q == 5'd31);

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide controller with pipeline stall
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] reg_s_val,
    input  logic [31:0] reg_t_val,
    input  logic        flush,
    output logic [63:0] hilo_value,
    output logic        stall_for_mul_cycle,
    output logic        done,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [63:0] hilo_q, hilo_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        mul_sgn_q, mul_sgn_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_load, div_en, div_last;
    logic [31:0] div_quo, div_rem;
    logic [31:0] dvd_mag, dvs_mag;
    logic [63:0] ext_a, ext_b, product;
    logic        is_mul, is_div, can_accept, running;

    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign running    = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);

    assign dvd_mag = (op == OP_DIV) ? abs32(reg_s_val) : reg_s_val;
    assign dvs_mag = (op == OP_DIV) ? abs32(reg_t_val) : reg_t_val;

    assign ext_a   = mul_sgn_q ? {{32{mul_a_q[31]}}, mul_a_q} : {32'd0, mul_a_q};
    assign ext_b   = mul_sgn_q ? {{32{mul_b_q[31]}}, mul_b_q} : {32'd0, mul_b_q};
    assign product = ext_a * ext_b;

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .en        (div_en),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    always_comb begin
        state_d   = state_q;
        hilo_d    = hilo_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_sgn_d = mul_sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div_load  = 1'b0;
        div_en    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (op == OP_MTHI) begin
                        hilo_d[63:32] = reg_s_val;
                    end else if (op == OP_MTLO) begin
                        hilo_d[31:0] = reg_s_val;
                    end else if (is_mul) begin
                        mul_a_d   = reg_s_val;
                        mul_b_d   = reg_t_val;
                        mul_sgn_d = (op == OP_MULT);
                        state_d   = ST_MUL;
                    end else if (is_div) begin
                        if (reg_t_val == 32'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            div_load  = 1'b1;
                            neg_quo_d = (op == OP_DIV) && (reg_s_val[31] ^ reg_t_val[31]);
                            neg_rem_d = (op == OP_DIV) && reg_s_val[31];
                            state_d   = ST_DIV;
                        end
                    end
                end
            end
            ST_MUL: begin
                hilo_d  = product;
                state_d = ST_DONE;
            end
            ST_DIV: begin
                div_en = 1'b1;
                if (div_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                hilo_d[63:32] = neg_rem_q ? (32'd0 - div_rem) : div_rem;
                hilo_d[31:0]  = neg_quo_q ? (32'd0 - div_quo) : div_quo;
                state_d       = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush discards the operation and any start issued alongside it.
        if (flush) begin
            state_d  = ST_IDLE;
            hilo_d   = hilo_q;
            div_load = 1'b0;
            div_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hilo_q    <= 64'd0;
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            mul_sgn_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hilo_q    <= hilo_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_sgn_q <= mul_sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign hilo_value          = hilo_q;
    assign stall_for_mul_cycle = !rst && !flush &&
                                 ((start && (is_mul || is_div) && can_accept) || running);
    assign done                = !rst && (state_q == ST_DONE);
    assign busy                = !rst && (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] reg_s_val = 32'd0;
    logic [31:0] reg_t_val = 32'd0;
    logic        flush = 1'b0;
    logic [63:0] hilo_value;
    logic        stall_for_mul_cycle;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] model_hilo = 64'd0;

    muldiv_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .op                  (op),
        .reg_s_val           (reg_s_val),
        .reg_t_val           (reg_t_val),
        .flush               (flush),
        .hilo_value          (hilo_value),
        .stall_for_mul_cycle (stall_for_mul_cycle),
        .done                (done),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result and done latency of one operation, from plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] exp, output int lat);
        longint sa, sb, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        exp = model_hilo;
        lat = 0;
        case (o)
            3'd1: begin exp = 64'(sa * sb); lat = 2; end
            3'd2: begin exp = {32'd0, a} * {32'd0, b}; lat = 2; end
            3'd3: begin
                if (b == 32'd0) lat = 1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    exp = {r[31:0], q[31:0]};
                    lat = 34;
                end
            end
            3'd4: begin
                if (b == 32'd0) lat = 1;
                else begin exp = {a % b, a / b}; lat = 34; end
            end
            3'd5: exp = {a, model_hilo[31:0]};
            3'd6: exp = {model_hilo[63:32], a};
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat;
        model(o, a, b, exp, lat);
        start = 1'b1; op = o; reg_s_val = a; reg_t_val = b;
        @(negedge clk);
        chk("stall_c0", stall_for_mul_cycle, 64'(lat > 0));
        tick();
        start = (lat > 1) ? 1'($urandom) : 1'b0;
        op = 3'($urandom); reg_s_val = $urandom; reg_t_val = $urandom;
        if (lat == 0) begin
            @(negedge clk);
            chk("hilo_mt", hilo_value, exp);
            chk("busy_mt", busy, 0);
            chk("done_mt", done, 0);
            tick();
        end
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            chk("stall_run", stall_for_mul_cycle, 64'(cyc < lat));
            chk("done_run", done, 64'(cyc == lat));
            chk("busy_run", busy, 1);
            if (cyc == lat) chk("hilo_res", hilo_value, exp);
            tick();
            start = (cyc + 1 < lat) ? 1'($urandom) : 1'b0;
            op = 3'($urandom); reg_s_val = $urandom; reg_t_val = $urandom;
        end
        start = 1'b0;
        model_hilo = exp;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        // Reset overrides a concurrent start.
        start = 1'b1; op = 3'd1; reg_s_val = 32'd5; reg_t_val = 32'd6;
        tick(); tick();
        @(negedge clk);
        chk("rst_hilo", hilo_value, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_for_mul_cycle, 0);
        tick();
        start = 1'b0; rst = 1'b0;
        tick();
        chk("post_rst_hilo", hilo_value, 0);

        run_op(3'd1, 32'hFFFFFFFE, 32'h00000003);
        chk("mult_const", hilo_value, 64'hFFFFFFFF_FFFFFFFA);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_const", hilo_value, 64'hFFFFFFFE_00000001);
        run_op(3'd3, 32'hFFFFFFF9, 32'h00000002);
        chk("div_const", hilo_value, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_const", hilo_value, 64'h00000000_80000000);

        run_op(3'd5, 32'h11111111, 32'd0);
        run_op(3'd6, 32'h22222222, 32'd0);
        run_op(3'd4, 32'd100, 32'd0);
        chk("div0_const", hilo_value, 64'h11111111_22222222);

        // Flush at cycle 10 of a DIVU, with a start in the flush cycle.
        start = 1'b1; op = 3'd4; reg_s_val = 32'd100; reg_t_val = 32'd7;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1; start = 1'b1; op = 3'd5; reg_s_val = 32'hDEADBEEF;
        @(negedge clk);
        chk("flush_stall", stall_for_mul_cycle, 0);
        chk("flush_done", done, 0);
        tick();
        flush = 1'b0; start = 1'b1; op = 3'd6; reg_s_val = 32'h00001234;
        @(negedge clk);
        chk("flush_hilo", hilo_value, model_hilo);
        chk("flush_busy", busy, 0);
        chk("flush_done2", done, 0);
        chk("mtlo_stall", stall_for_mul_cycle, 0);
        tick();
        start = 1'b0;
        model_hilo = {model_hilo[63:32], 32'h00001234};
        chk("mtlo_after_flush", hilo_value, model_hilo);

        // Reset at cycle 15 of a DIV.
        start = 1'b1; op = 3'd3; reg_s_val = 32'hFFFF0000; reg_t_val = 32'd3;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstdiv_stall", stall_for_mul_cycle, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstdiv_busy", busy, 0);
        chk("rstdiv_hilo", hilo_value, 0);
        chk("rstdiv_stall2", stall_for_mul_cycle, 0);
        model_hilo = 64'd0;
        for (int c = 0; c < 40; c++) begin
            chk("rstdiv_nodone", done, 0);
            tick();
            @(negedge clk);
        end
        tick();

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: ra = 32'($urandom_range(0, 50));
                default: ;
            endcase
            run_op(ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
